ov7670_word_pack: RTL and testbench
===================================

# ov7670_word_pack

Downstream stage of the camera capture path, clocked on pclk. It consumes the capture stage's byte-lane framebuffer write stream: a high byte on lane 1, then a low byte on lane 0, both at the same address. It merges each pair into one RGB565 word, converts the word to RGB444, and issues a single 12-bit write to the framebuffer. It also keeps per-frame pixel and error statistics for the status registers.

## Interface
Parameters:
- AW, 19, address width of the input stream and of the framebuffer.
- MAX_PIXELS, 307200, number of framebuffer words (640x480). Writes at addr >= MAX_PIXELS are dropped.

Ports:
- pclk  in  1  camera pixel clock.
- rst_n  in  1  reset; asynchronous, active-low.
- vsync  in  1  camera vsync, raw, high between frames.
- in_addr  in  AW  byte-pair address from the capture stage.
- in_data  in  8  byte from the capture stage.
- in_we  in  2  lane enables: [1] marks the high (RG) byte, [0] marks the low (BX) byte.
- fb_addr  out  AW  framebuffer write address.
- fb_data  out  12  RGB444 pixel: {r[4:1], g[5:2], b[4:1]} of RGB565 word {hi,lo}.
- fb_we  out  1  framebuffer write strobe, one cycle per pixel.
- frame_done  out  1  one-cycle pulse at each vsync rising edge.
- frame_pixels  out  AW  pixels written in the last completed frame.
- frame_err  out  1  the last completed frame had at least one protocol error.
- oob_err  out  1  sticky: at least one write was dropped for addr >= MAX_PIXELS. Cleared only by reset.

## Operation
- FSM has two states, WAIT_HI and WAIT_LO. Reset state is WAIT_HI.
- WAIT_HI:
  - in_we=10: latch in_data as hi and in_addr as held_addr; go to WAIT_LO.
  - in_we=01 (orphan low byte): drop it, set err_cur.
  - in_we=00: stay.
- WAIT_LO:
  - in_we=01 with in_addr==held_addr: emit a write and return to WAIT_HI.
    - If held_addr >= MAX_PIXELS, suppress the write and set oob_err.
    - Otherwise increment pix_cnt.
  - in_we=01 with a mismatched address: drop, set err_cur, return to WAIT_HI.
  - in_we=10 (second high byte): overwrite hi and held_addr, set err_cur, stay in WAIT_LO.
  - in_we=00: stay; the FSM waits indefinitely.
- in_we=11 in either state: drop, set err_cur, go to WAIT_HI.
- vsync=1 has priority over everything:
  - FSM goes to WAIT_HI and any held byte is discarded without an error.
  - in_we is ignored.
  - fb_we is 0 in the following cycle.
- Frame boundary, detected with registered vsync_d (rise = vsync & ~vsync_d):
  - frame_pixels <= pix_cnt and frame_err <= err_cur.
  - pix_cnt <= 0 and err_cur <= 0.
  - frame_done pulses for one cycle.
  - An error or pixel in that same cycle cannot occur, because vsync masks input.
- pix_cnt saturates at 2^AW-1.
- Conversion is combinational on the registered pair; the output is registered.

## Timing
- Reset values: fb_addr=0, fb_data=0, fb_we=0, frame_done=0, frame_pixels=0, frame_err=0, oob_err=0. Internal state: FSM=WAIT_HI, hi=0, held_addr=0, pix_cnt=0, err_cur=0, vsync_d=0.
- Latency: high byte at cycle n, matching low byte at cycle n+1, then fb_we=1 with fb_addr/fb_data valid in cycle n+2.
  - Back-to-back pairs produce a write every second cycle.
- fb_we is high for exactly one cycle per pixel. fb_addr and fb_data hold their last value when fb_we=0.
- frame_done is asserted in the cycle after vsync is first sampled high. frame_pixels and frame_err update in that same cycle and are stable until the next frame_done.
- Reset mid-pair: the held byte is lost, with no spurious write after release.

## Structure
- Package ov7670_pkg holds:
  - enum pack_state_t {WAIT_HI, WAIT_LO}.
  - Function rgb565_to_444.
  - Constant FRAME_PIXELS = 307200, shared with the capture and display stages.
- One sub-module, ov7670_frame_stats: vsync edge detect, pix_cnt/err_cur accumulation, and the frame_done/frame_pixels/frame_err registers. The packer FSM and output register stay in the top module.

## Test plan
- Pairs (10,addr 5,data F8) then (01,addr 5,data 1F), i.e. RGB565 F81F → fb_we=1 two cycles after the high byte, fb_addr=5, fb_data=F0F.
- 100 legal pairs at addresses 0..99, then vsync high → frame_done pulses once, frame_pixels=100, frame_err=0, and the next frame count starts at 0.
- Orphan 01 in WAIT_HI; 10,10,01 at the same address; 11 → no write from the orphan or the 11; exactly one write carrying the second high byte; frame_err=1 at the next frame_done.
- High byte at addr 7, low byte at addr 8 → no write, err_cur set, FSM back to WAIT_HI.
- Pair at addr 307200 → no fb_we, oob_err=1 and still 1 after a vsync.
- High byte, then vsync=1, then 01 → no write, no error. Also assert rst_n low between the bytes of a pair → all outputs at reset values and no write after release.

Source files
------------

// File: rtl/ov7670_pkg.sv
// ov7670_pkg
// Shared definitions for the OV7670 capture path: the word packer state
// encoding, the RGB565 -> RGB444 reduction used before framebuffer writes,
// and the framebuffer size shared by the capture and display stages.
package ov7670_pkg;

  // Framebuffer depth in words (640x480).
  localparam int FRAME_PIXELS = 307200;

  // Packer FSM: waiting for the high (RG) byte, or holding it and waiting
  // for the matching low (BX) byte.
  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } pack_state_t;

  // Keep the top 4 bits of each colour channel of an RGB565 word
  // {r[4:0], g[5:0], b[4:0]}.
  function automatic logic [11:0] rgb565_to_444(input logic [15:0] rgb565);
    return {rgb565[15:12], rgb565[10:7], rgb565[4:1]};
  endfunction

endpackage

// File: rtl/ov7670_frame_stats.sv
// ov7670_frame_stats
// Per-frame statistics for the word packer. Detects the vsync rising edge,
// accumulates written pixels and protocol errors for the frame in progress,
// and latches them into the status registers at each frame boundary.
//
// Ports:
//   pclk, rst_n   - camera pixel clock, asynchronous active-low reset
//   vsync         - raw camera vsync, high between frames
//   pix_inc       - one pixel was written to the framebuffer this cycle
//   err_set       - a protocol error was seen this cycle
//   frame_done    - one-cycle pulse after vsync is first sampled high
//   frame_pixels  - pixels written in the last completed frame
//   frame_err     - last completed frame had at least one protocol error
module ov7670_frame_stats #(
  parameter int AW = 19
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          pix_inc,
  input  logic          err_set,
  output logic          frame_done,
  output logic [AW-1:0] frame_pixels,
  output logic          frame_err
);

  logic          vsync_d;
  logic [AW-1:0] pix_cnt;
  logic          err_cur;
  logic          vsync_rise;

  assign vsync_rise = vsync & ~vsync_d;

  // On a vsync rise the running counters are published and cleared. The
  // packer masks its inputs while vsync is high, so no pixel or error can
  // arrive in the same cycle as the rise and none is lost here.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d      <= 1'b0;
      pix_cnt      <= '0;
      err_cur      <= 1'b0;
      frame_done   <= 1'b0;
      frame_pixels <= '0;
      frame_err    <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      frame_done <= vsync_rise;
      if (vsync_rise) begin
        frame_pixels <= pix_cnt;
        frame_err    <= err_cur;
        pix_cnt      <= '0;
        err_cur      <= 1'b0;
      end else begin
        // Saturate rather than wrap so a runaway frame never reads as small.
        if (pix_inc && (pix_cnt != '1)) begin
          pix_cnt <= pix_cnt + 1'b1;
        end
        if (err_set) begin
          err_cur <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ov7670_word_pack.sv
// ov7670_word_pack
// Merges the capture stage's byte-lane write stream (high byte on lane 1,
// then low byte on lane 0 at the same address) into one RGB565 word,
// reduces it to RGB444 and issues a single 12-bit framebuffer write.
//
// Ports:
//   pclk, rst_n   - camera pixel clock, asynchronous active-low reset
//   vsync         - raw camera vsync; while high all input is ignored
//   in_addr       - byte-pair address from the capture stage
//   in_data       - byte from the capture stage
//   in_we         - lane enables: [1] high (RG) byte, [0] low (BX) byte
//   fb_addr       - framebuffer write address (holds when fb_we=0)
//   fb_data       - RGB444 pixel (holds when fb_we=0)
//   fb_we         - one-cycle write strobe per pixel
//   frame_done    - one-cycle pulse at each vsync rising edge
//   frame_pixels  - pixels written in the last completed frame
//   frame_err     - last completed frame had a protocol error
//   oob_err       - sticky: a write at addr >= MAX_PIXELS was dropped
module ov7670_word_pack
  import ov7670_pkg::*;
#(
  parameter int AW         = 19,
  parameter int MAX_PIXELS = FRAME_PIXELS
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic [AW-1:0] in_addr,
  input  logic [7:0]    in_data,
  input  logic [1:0]    in_we,
  output logic [AW-1:0] fb_addr,
  output logic [11:0]   fb_data,
  output logic          fb_we,
  output logic          frame_done,
  output logic [AW-1:0] frame_pixels,
  output logic          frame_err,
  output logic          oob_err
);

  // One extra bit so a limit equal to 2^AW still compares correctly.
  localparam logic [AW:0] PIXEL_LIMIT = (AW + 1)'(MAX_PIXELS);

  pack_state_t   state;
  logic [7:0]    hi;
  logic [AW-1:0] held_addr;

  logic lo_match;
  logic held_oob;
  logic pair_done;
  logic pix_inc;
  logic err_set;

  assign lo_match  = (in_addr == held_addr);
  assign held_oob  = ({1'b0, held_addr} >= PIXEL_LIMIT);
  assign pair_done = !vsync && (state == WAIT_LO) && (in_we == 2'b01) && lo_match;
  assign pix_inc   = pair_done && !held_oob;

  // Protocol errors: both lanes at once, an orphan low byte, a low byte at
  // the wrong address, or a second high byte before its low byte.
  assign err_set = !vsync && ((in_we == 2'b11) ||
                              ((state == WAIT_HI) && (in_we == 2'b01)) ||
                              ((state == WAIT_LO) && (in_we == 2'b01) && !lo_match) ||
                              ((state == WAIT_LO) && (in_we == 2'b10)));

  // Packer FSM with registered framebuffer outputs. A high byte always
  // (re)loads the holding registers; a second one simply replaces the first.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= WAIT_HI;
      hi        <= 8'h00;
      held_addr <= '0;
      fb_addr   <= '0;
      fb_data   <= 12'h000;
      fb_we     <= 1'b0;
      oob_err   <= 1'b0;
    end else begin
      fb_we <= 1'b0;
      if (vsync) begin
        state <= WAIT_HI;
      end else begin
        case (in_we)
          2'b11: state <= WAIT_HI;
          2'b10: begin
            hi        <= in_data;
            held_addr <= in_addr;
            state     <= WAIT_LO;
          end
          2'b01: begin
            if (state == WAIT_LO) begin
              state <= WAIT_HI;
              if (lo_match) begin
                if (held_oob) begin
                  oob_err <= 1'b1;
                end else begin
                  fb_we   <= 1'b1;
                  fb_addr <= held_addr;
                  fb_data <= rgb565_to_444({hi, in_data});
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  ov7670_frame_stats #(
    .AW(AW)
  ) u_stats (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .pix_inc     (pix_inc),
    .err_set     (err_set),
    .frame_done  (frame_done),
    .frame_pixels(frame_pixels),
    .frame_err   (frame_err)
  );

endmodule

// File: tb/tb_ov7670_word_pack.sv
// tb_ov7670_word_pack
// Self-checking bench for ov7670_word_pack: a table of directed vectors with
// hand-computed expectations, hand-written frame/reset sequences, and a
// randomized phase, all checked every cycle against a behavioural model.
module tb_ov7670_word_pack;

  localparam int AW = 19;
  localparam int LIMIT = 307200;

  logic          pclk = 1'b0;
  logic          rst_n = 1'b0;
  logic          vsync = 1'b0;
  logic [AW-1:0] in_addr = '0;
  logic [7:0]    in_data = 8'h00;
  logic [1:0]    in_we = 2'b00;
  logic [AW-1:0] fb_addr;
  logic [11:0]   fb_data;
  logic          fb_we;
  logic          frame_done;
  logic [AW-1:0] frame_pixels;
  logic          frame_err;
  logic          oob_err;

  int checks = 0;
  int failures = 0;

  ov7670_word_pack #(
    .AW(AW),
    .MAX_PIXELS(LIMIT)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .vsync       (vsync),
    .in_addr     (in_addr),
    .in_data     (in_data),
    .in_we       (in_we),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data),
    .fb_we       (fb_we),
    .frame_done  (frame_done),
    .frame_pixels(frame_pixels),
    .frame_err   (frame_err),
    .oob_err     (oob_err)
  );

  always #5 pclk = ~pclk;

  // Behavioural model: a pending high byte (if any) and frame tallies.
  bit m_have_hi;
  int m_hi, m_haddr, m_pix;
  bit m_err, m_vprev;
  int e_fb_we, e_fb_addr, e_fb_data, e_done, e_fpix, e_ferr, e_oob;

  typedef struct {
    int v, we, a, d;
    int x_we, x_addr, x_data, x_done, x_fpix, x_ferr, x_oob;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(int v, int we, int a, int d, int xwe, int xaddr, int xdata,
                              int xdone, int xfpix, int xferr, int xoob);
    vec_t r;
    r.v = v; r.we = we; r.a = a; r.d = d;
    r.x_we = xwe; r.x_addr = xaddr; r.x_data = xdata; r.x_done = xdone;
    r.x_fpix = xfpix; r.x_ferr = xferr; r.x_oob = xoob;
    return r;
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_have_hi = 0; m_hi = 0; m_haddr = 0; m_pix = 0; m_err = 0; m_vprev = 0;
    e_fb_we = 0; e_fb_addr = 0; e_fb_data = 0; e_done = 0; e_fpix = 0; e_ferr = 0; e_oob = 0;
  endtask

  // Apply one cycle of input to the model: what the outputs should show
  // right after the clock edge that samples these inputs.
  task automatic modelStep(input int v, input int we, input int a, input int d);
    int word;
    e_fb_we = 0;
    e_done = 0;
    if (v != 0 && !m_vprev) begin
      e_done = 1; e_fpix = m_pix; e_ferr = int'(m_err);
      m_pix = 0; m_err = 0;
    end
    m_vprev = (v != 0);
    if (v != 0) begin
      m_have_hi = 0;
    end else if (we == 3) begin
      m_err = 1; m_have_hi = 0;
    end else if (we == 2) begin
      if (m_have_hi) m_err = 1;
      m_have_hi = 1; m_hi = d; m_haddr = a;
    end else if (we == 1) begin
      if (!m_have_hi) begin
        m_err = 1;
      end else if (a != m_haddr) begin
        m_err = 1; m_have_hi = 0;
      end else begin
        m_have_hi = 0;
        if (m_haddr >= LIMIT) begin
          e_oob = 1;
        end else begin
          word = m_hi * 256 + d;
          e_fb_we = 1;
          e_fb_addr = m_haddr;
          e_fb_data = ((word >> 12) & 15) * 256 + ((word >> 7) & 15) * 16 + ((word >> 1) & 15);
          if (m_pix < (1 << AW) - 1) m_pix++;
        end
      end
    end
  endtask

  task automatic checkOutput();
    cmp("fb_we", int'(fb_we), e_fb_we);
    cmp("fb_addr", int'(fb_addr), e_fb_addr);
    cmp("fb_data", int'(fb_data), e_fb_data);
    cmp("frame_done", int'(frame_done), e_done);
    cmp("frame_pixels", int'(frame_pixels), e_fpix);
    cmp("frame_err", int'(frame_err), e_ferr);
    cmp("oob_err", int'(oob_err), e_oob);
  endtask

  // Called #1 after a rising edge; drives inputs, clocks once, checks.
  task automatic applyStimulus(input int v, input int we, input int a, input int d);
    vsync   = (v != 0);
    in_we   = 2'(we);
    in_addr = AW'(a);
    in_data = 8'(d);
    modelStep(v, we, a, d);
    @(posedge pclk);
    #1;
    checkOutput();
  endtask

  initial begin
    int vs, lastA, r, we, a;

    // Directed vectors: {vsync, we, addr, data, exp we, addr, data, done, pixels, err, oob}
    vecs[0]  = mk(0, 2, 5, 'hF8,      0, 0, 0,       0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 5, 'h1F,      1, 5, 'hF0F,   0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 'h00,      0, 0, 0,       0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 3, 'hAA,      0, 0, 0,       0, 0, 0, 0);
    vecs[4]  = mk(0, 2, 9, 'h12,      0, 0, 0,       0, 0, 0, 0);
    vecs[5]  = mk(0, 2, 9, 'h34,      0, 0, 0,       0, 0, 0, 0);
    vecs[6]  = mk(0, 1, 9, 'h56,      1, 9, 'h38B,   0, 0, 0, 0);
    vecs[7]  = mk(0, 3, 9, 'h00,      0, 0, 0,       0, 0, 0, 0);
    vecs[8]  = mk(0, 2, 7, 'h11,      0, 0, 0,       0, 0, 0, 0);
    vecs[9]  = mk(0, 1, 8, 'h22,      0, 0, 0,       0, 0, 0, 0);
    vecs[10] = mk(0, 1, 8, 'h22,      0, 0, 0,       0, 0, 0, 0);
    vecs[11] = mk(1, 0, 0, 'h00,      0, 0, 0,       1, 2, 1, 0);
    vecs[12] = mk(0, 0, 0, 'h00,      0, 0, 0,       0, 2, 1, 0);
    vecs[13] = mk(0, 2, LIMIT, 'hFF,  0, 0, 0,       0, 2, 1, 0);
    vecs[14] = mk(0, 1, LIMIT, 'h00,  0, 0, 0,       0, 2, 1, 1);
    vecs[15] = mk(1, 0, 0, 'h00,      0, 0, 0,       1, 0, 0, 1);
    vecs[16] = mk(0, 2, 4, 'h77,      0, 0, 0,       0, 0, 0, 1);
    vecs[17] = mk(1, 1, 4, 'h11,      0, 0, 0,       1, 0, 0, 1);
    vecs[18] = mk(1, 1, 4, 'h11,      0, 0, 0,       0, 0, 0, 1);
    vecs[19] = mk(0, 0, 0, 'h00,      0, 0, 0,       0, 0, 0, 1);
    vecs[20] = mk(1, 0, 0, 'h00,      0, 0, 0,       1, 0, 0, 1);
    vecs[21] = mk(0, 1, 4, 'h11,      0, 0, 0,       0, 0, 0, 1);

    // Reset state
    modelReset();
    repeat (3) @(posedge pclk);
    #1;
    checkOutput();
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 22; i++) begin
      applyStimulus(vecs[i].v, vecs[i].we, vecs[i].a, vecs[i].d);
      cmp($sformatf("vec%0d_we", i), int'(fb_we), vecs[i].x_we);
      if (vecs[i].x_we != 0) begin
        cmp($sformatf("vec%0d_addr", i), int'(fb_addr), vecs[i].x_addr);
        cmp($sformatf("vec%0d_data", i), int'(fb_data), vecs[i].x_data);
      end
      cmp($sformatf("vec%0d_done", i), int'(frame_done), vecs[i].x_done);
      cmp($sformatf("vec%0d_pixels", i), int'(frame_pixels), vecs[i].x_fpix);
      cmp($sformatf("vec%0d_ferr", i), int'(frame_err), vecs[i].x_ferr);
      cmp($sformatf("vec%0d_oob", i), int'(oob_err), vecs[i].x_oob);
    end

    // 100 legal pairs in a clean frame, then a frame boundary
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      applyStimulus(0, 2, i, int'($urandom_range(0, 255)));
      applyStimulus(0, 1, i, int'($urandom_range(0, 255)));
    end
    applyStimulus(1, 0, 0, 0);
    cmp("hundred_done", int'(frame_done), 1);
    cmp("hundred_pixels", int'(frame_pixels), 100);
    cmp("hundred_err", int'(frame_err), 0);
    applyStimulus(1, 0, 0, 0);
    cmp("done_one_cycle", int'(frame_done), 0);
    applyStimulus(0, 2, 0, 'h12);
    applyStimulus(0, 1, 0, 'h34);
    applyStimulus(1, 0, 0, 0);
    cmp("next_frame_pixels", int'(frame_pixels), 1);
    applyStimulus(0, 0, 0, 0);

    // Reset between the bytes of a pair
    applyStimulus(0, 2, 5, 'hAB);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput();
    @(posedge pclk);
    #1;
    checkOutput();
    rst_n = 1'b1;
    applyStimulus(0, 1, 5, 'hCD);
    cmp("post_reset_no_write", int'(fb_we), 0);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    cmp("post_reset_orphan_err", int'(frame_err), 1);

    // Randomized traffic against the model
    vs = 0;
    lastA = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) vs = 1 - vs;
      r = int'($urandom_range(0, 9));
      we = (r < 2) ? 0 : (r < 6) ? 2 : (r < 9) ? 1 : 3;
      if (we == 1 && $urandom_range(0, 3) != 0) begin
        a = lastA;
      end else if ($urandom_range(0, 24) == 0) begin
        a = LIMIT + int'($urandom_range(0, 7));
      end else begin
        a = int'($urandom_range(0, 15));
      end
      if (we == 2) lastA = a;
      applyStimulus(vs, we, a, int'($urandom_range(0, 255)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
